// File: rtl/l2_fwd_stall_buf.sv
// Stall buffer for forwarded coherence messages blocked on a busy L2 MSHR entry.
// Entries become eligible when their MSHR entry wakes and replay oldest-first.
module l2_fwd_stall_buf #(
    parameter int N_ENTRIES = 4,
    parameter int REQS_BITS = 2,
    parameter int MSG_W     = 5,
    parameter int LINE_W    = 26,
    parameter int ID_W      = 4,
    parameter int CNT_W     = $clog2(N_ENTRIES) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [MSG_W-1:0]     push_msg,
    input  logic [LINE_W-1:0]    push_line,
    input  logic [ID_W-1:0]      push_req_id,
    input  logic [REQS_BITS-1:0] push_reqs_i,
    input  logic                 wake_valid,
    input  logic [REQS_BITS-1:0] wake_reqs_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MSG_W-1:0]     out_msg,
    output logic [LINE_W-1:0]    out_line,
    output logic [ID_W-1:0]      out_req_id,
    output logic [REQS_BITS-1:0] out_reqs_i,
    output logic [CNT_W-1:0]     count,
    output logic                 fwd_stall
);

    localparam int AGE_W = $clog2(N_ENTRIES);
    localparam int IDX_W = $clog2(N_ENTRIES);

    logic [N_ENTRIES-1:0] valid_q, valid_d;
    logic [N_ENTRIES-1:0] elig_q, elig_d;
    logic [AGE_W-1:0]     age_q [N_ENTRIES];
    logic [AGE_W-1:0]     age_d [N_ENTRIES];
    logic [MSG_W-1:0]     msg_q [N_ENTRIES];
    logic [LINE_W-1:0]    line_q [N_ENTRIES];
    logic [ID_W-1:0]      id_q [N_ENTRIES];
    logic [REQS_BITS-1:0] reqs_q [N_ENTRIES];
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 lock_q, lock_d;
    logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;

    logic                 any_elig;
    logic [IDX_W-1:0]     min_idx;
    logic [AGE_W-1:0]     min_age;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     sel_idx;
    logic [AGE_W-1:0]     sel_age;
    logic                 push_fire;
    logic                 pop_fire;

    always_comb begin
        any_elig = 1'b0;
        min_idx  = '0;
        min_age  = '1;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (valid_q[i] && elig_q[i] && (!any_elig || age_q[i] < min_age)) begin
                any_elig = 1'b1;
                min_age  = age_q[i];
                min_idx  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    // A held handshake keeps presenting the latched slot even if an older one wakes.
    assign sel_idx    = lock_q ? lock_idx_q : min_idx;
    assign sel_age    = age_q[sel_idx];
    assign out_valid  = lock_q | any_elig;
    assign push_ready = (count_q != CNT_W'(N_ENTRIES));
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = out_valid && out_ready;

    always_comb begin
        valid_d    = valid_q;
        elig_d     = elig_q;
        age_d      = age_q;
        count_d    = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (valid_q[i]) begin
                if (wake_valid && reqs_q[i] == wake_reqs_i) elig_d[i] = 1'b1;
                if (pop_fire && age_q[i] > sel_age) age_d[i] = age_q[i] - AGE_W'(1);
            end
        end
        if (pop_fire) begin
            valid_d[sel_idx] = 1'b0;
            elig_d[sel_idx]  = 1'b0;
        end
        if (push_fire) begin
            valid_d[free_idx] = 1'b1;
            elig_d[free_idx]  = wake_valid && (wake_reqs_i == push_reqs_i);
            age_d[free_idx]   = AGE_W'(count_q - CNT_W'(pop_fire));
        end
        if (pop_fire) begin
            lock_d = 1'b0;
        end else if (out_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            elig_q     <= '0;
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            elig_q     <= elig_d;
            count_q    <= count_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            age_q      <= age_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                msg_q[i]  <= '0;
                line_q[i] <= '0;
                id_q[i]   <= '0;
                reqs_q[i] <= '0;
            end
        end else if (push_fire) begin
            msg_q[free_idx]  <= push_msg;
            line_q[free_idx] <= push_line;
            id_q[free_idx]   <= push_req_id;
            reqs_q[free_idx] <= push_reqs_i;
        end
    end

    assign out_msg    = out_valid ? msg_q[sel_idx]  : '0;
    assign out_line   = out_valid ? line_q[sel_idx] : '0;
    assign out_req_id = out_valid ? id_q[sel_idx]   : '0;
    assign out_reqs_i = out_valid ? reqs_q[sel_idx] : '0;
    assign count      = count_q;
    assign fwd_stall  = |(valid_q & ~elig_q);

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        push_fire |-> (count_q < CNT_W'(N_ENTRIES)));

    a_count_max: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(N_ENTRIES));

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_msg) &&
        $stable(out_line) && $stable(out_req_id) && $stable(out_reqs_i)));

endmodule

// File: tb/tb_l2_fwd_stall_buf.sv
// Randomized scoreboard bench for l2_fwd_stall_buf against an age-ordered queue model.
module tb_l2_fwd_stall_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [4:0]  push_msg;
    logic [25:0] push_line;
    logic [3:0]  push_req_id;
    logic [1:0]  push_reqs_i;
    logic        wake_valid;
    logic [1:0]  wake_reqs_i;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_msg;
    logic [25:0] out_line;
    logic [3:0]  out_req_id;
    logic [1:0]  out_reqs_i;
    logic [2:0]  count;
    logic        fwd_stall;

    always #5 clk = ~clk;

    l2_fwd_stall_buf dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_msg(push_msg), .push_line(push_line),
        .push_req_id(push_req_id), .push_reqs_i(push_reqs_i),
        .wake_valid(wake_valid), .wake_reqs_i(wake_reqs_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_msg(out_msg), .out_line(out_line),
        .out_req_id(out_req_id), .out_reqs_i(out_reqs_i),
        .count(count), .fwd_stall(fwd_stall)
    );

    typedef struct {
        logic [4:0]  msg;
        logic [25:0] line;
        logic [3:0]  id;
        logic [1:0]  reqs;
        bit          elig;
    } ent_t;

    ent_t mq[$];
    ent_t scb[$];
    ent_t me;
    int   lock_line = -1;
    int   seq = 1;
    int   total = 0;
    int   bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Held handshake entry first, otherwise the oldest eligible entry.
    function automatic int find_sel();
        if (lock_line >= 0)
            foreach (mq[i]) if (int'(mq[i].line) == lock_line) return i;
        foreach (mq[i]) if (mq[i].elig) return i;
        return -1;
    endfunction

    task automatic check_outputs();
        int   s;
        bit   st;
        ent_t e;
        s  = find_sel();
        st = 1'b0;
        foreach (mq[i]) if (!mq[i].elig) st = 1'b1;
        e = '{default: '0};
        if (s >= 0) e = mq[s];
        chk("count", 32'(count), 32'(mq.size()));
        chk("push_ready", 32'(push_ready), 32'(mq.size() != 4));
        chk("fwd_stall", 32'(fwd_stall), 32'(st));
        chk("out_valid", 32'(out_valid), 32'(s >= 0));
        chk("out_msg", 32'(out_msg), 32'(e.msg));
        chk("out_line", 32'(out_line), 32'(e.line));
        chk("out_req_id", 32'(out_req_id), 32'(e.id));
        chk("out_reqs_i", 32'(out_reqs_i), 32'(e.reqs));
    endtask

    task automatic step(bit r, bit pv, bit wv, logic [1:0] wr, bit ordy, logic [1:0] preqs);
        int   s;
        bit   pop;
        bit   canpush;
        ent_t e;
        rst         = r;
        push_valid  = pv;
        push_msg    = 5'($urandom);
        push_line   = 26'(seq);
        push_req_id = 4'($urandom);
        push_reqs_i = preqs;
        wake_valid  = wv;
        wake_reqs_i = wr;
        out_ready   = ordy;
        if (r) begin
            mq.delete();
            lock_line = -1;
        end else begin
            s       = find_sel();
            pop     = (s >= 0) && ordy;
            canpush = (mq.size() != 4);
            if (pop) begin
                scb.push_back(mq[s]);
                mq.delete(s);
                lock_line = -1;
            end else if (s >= 0) begin
                lock_line = int'(mq[s].line);
            end
            if (wv) foreach (mq[i]) if (mq[i].reqs == wr) mq[i].elig = 1'b1;
            if (pv && canpush) begin
                e.msg  = push_msg;
                e.line = push_line;
                e.id   = push_req_id;
                e.reqs = preqs;
                e.elig = wv && (wr == preqs);
                mq.push_back(e);
                seq++;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    always @(negedge clk) begin
        #4;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (scb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got line %0h want no pop", out_line);
            end else begin
                me = scb.pop_front();
                chk("pop_line", 32'(out_line), 32'(me.line));
                chk("pop_msg", 32'(out_msg), 32'(me.msg));
                chk("pop_req_id", 32'(out_req_id), 32'(me.id));
                chk("pop_reqs_i", 32'(out_reqs_i), 32'(me.reqs));
            end
        end
    end

    initial begin
        int pp;
        int pw;
        int pr;
        rst         = 1'b1;
        push_valid  = 1'b0;
        push_msg    = '0;
        push_line   = '0;
        push_req_id = '0;
        push_reqs_i = '0;
        wake_valid  = 1'b0;
        wake_reqs_i = '0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();

        step(0, 1, 0, 2'd0, 1, 2'd1);
        repeat (10) step(0, 0, 0, 2'd0, 1, 2'd0);
        step(0, 0, 1, 2'd1, 0, 2'd0);
        step(0, 0, 0, 2'd0, 1, 2'd0);
        step(0, 1, 1, 2'd3, 0, 2'd3);
        step(0, 0, 0, 2'd0, 1, 2'd0);

        step(0, 1, 0, 2'd0, 0, 2'd1);
        step(0, 1, 0, 2'd0, 0, 2'd2);
        step(0, 1, 0, 2'd0, 0, 2'd1);
        step(0, 1, 0, 2'd0, 0, 2'd3);
        step(0, 1, 1, 2'd2, 0, 2'd0);
        step(0, 1, 1, 2'd1, 0, 2'd0);
        step(0, 0, 0, 2'd0, 0, 2'd0);
        repeat (5) step(0, 1, 0, 2'd0, 1, 2'd0);

        step(0, 0, 0, 2'd0, 0, 2'd0);
        step(1, 0, 0, 2'd0, 0, 2'd0);

        for (int ph = 0; ph < 3; ph++) begin
            pp = (ph == 0) ? 80 : (ph == 1) ? 50 : 30;
            pw = (ph == 0) ? 15 : (ph == 1) ? 35 : 60;
            pr = (ph == 0) ? 30 : (ph == 1) ? 60 : 85;
            for (int c = 0; c < 400; c++) begin
                step((ph == 1 && c == 200),
                     $urandom_range(0, 99) < pp,
                     $urandom_range(0, 99) < pw,
                     2'($urandom),
                     $urandom_range(0, 99) < pr,
                     2'($urandom));
            end
        end

        for (int c = 0; c < 16; c++) step(0, 0, 1, 2'(c), 1, 2'd0);
        #5;
        chk("scb_drained", 32'(scb.size()), 32'd0);
        chk("drain_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
